// File: rtl/dmem_arbiter_if.sv
// Requester and memory-side signals of the two-port data memory arbiter.
// The slave modport is the arbiter; the master modport is the requesters plus the memory.
interface dmem_arbiter_if #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned IDX_WIDTH  = 5
);
  logic [1:0]              req_valid;
  logic [1:0]              req_ready;
  logic [1:0]              req_we;
  logic [2*ADDR_WIDTH-1:0] req_addr;
  logic [2*DATA_WIDTH-1:0] req_wdata;
  logic [1:0]              rsp_valid;
  logic                    rsp_err;
  logic [DATA_WIDTH-1:0]   rsp_rdata;
  logic                    mem_en;
  logic                    mem_we;
  logic [IDX_WIDTH-1:0]    mem_idx;
  logic [DATA_WIDTH-1:0]   mem_wdata;
  logic [DATA_WIDTH-1:0]   mem_rdata;

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, mem_rdata,
    output req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_en, mem_we, mem_idx, mem_wdata
  );

  modport master (
    output req_valid, req_we, req_addr, req_wdata, mem_rdata,
    input  req_ready, rsp_valid, rsp_err, rsp_rdata,
           mem_en, mem_we, mem_idx, mem_wdata
  );
endinterface

// File: rtl/dmem_arbiter.sv
// Round-robin arbiter and sequencer for the single-port data memory:
// one access per 3 cycles, fixed accept-to-response latency of 2 cycles.
module dmem_arbiter #(
  parameter int unsigned ADDR_WIDTH = 32,
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned MEM_DEPTH  = 32,
  parameter int unsigned IDX_WIDTH  = $clog2(MEM_DEPTH)
) (
  input logic           clk,
  input logic           reset,
  dmem_arbiter_if.slave bus
);

  localparam int unsigned UPPER_W = ADDR_WIDTH - 2;

  typedef enum logic [1:0] {IDLE, ACCESS, RESP} state_t;

  state_t                r_state;
  logic                  r_rr_last;
  logic                  r_owner;
  logic                  r_we;
  logic                  r_legal;
  logic [1:0]            r_rsp_valid;
  logic                  r_rsp_err;
  logic                  r_mem_en;
  logic                  r_mem_we;
  logic [IDX_WIDTH-1:0]  r_mem_idx;
  logic [DATA_WIDTH-1:0] r_mem_wdata;

  logic                  w_win;
  logic [1:0]            w_ready;
  logic                  w_accept;
  logic                  w_we;
  logic [ADDR_WIDTH-1:0] w_addr;
  logic [DATA_WIDTH-1:0] w_wdata;
  logic                  w_legal;

  // Winner selection and combinational ready; ready is held low while in reset.
  always_comb begin
    w_win   = (bus.req_valid == 2'b11) ? ~r_rr_last : bus.req_valid[1];
    w_ready = 2'b00;
    if (reset && (r_state == IDLE) && bus.req_valid[w_win]) begin
      w_ready[w_win] = 1'b1;
    end
    w_accept = |w_ready;
    w_we     = bus.req_we[w_win];
    w_addr   = w_win ? bus.req_addr[2*ADDR_WIDTH-1:ADDR_WIDTH] : bus.req_addr[ADDR_WIDTH-1:0];
    w_wdata  = w_win ? bus.req_wdata[2*DATA_WIDTH-1:DATA_WIDTH] : bus.req_wdata[DATA_WIDTH-1:0];
    // Full upper-bit compare so out-of-range addresses never alias into memory.
    w_legal  = (w_addr[1:0] == 2'b00) && (w_addr[ADDR_WIDTH-1:2] < UPPER_W'(MEM_DEPTH));
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= IDLE;
      r_rr_last   <= 1'b1;
      r_owner     <= 1'b0;
      r_we        <= 1'b0;
      r_legal     <= 1'b0;
      r_rsp_valid <= 2'b00;
      r_rsp_err   <= 1'b0;
      r_mem_en    <= 1'b0;
      r_mem_we    <= 1'b0;
      r_mem_idx   <= '0;
      r_mem_wdata <= '0;
    end else begin
      case (r_state)
        IDLE: begin
          if (w_accept) begin
            r_state     <= ACCESS;
            r_owner     <= w_win;
            r_rr_last   <= w_win;
            r_we        <= w_we;
            r_legal     <= w_legal;
            r_mem_en    <= w_legal;
            r_mem_we    <= w_legal & w_we;
            r_mem_idx   <= w_legal ? w_addr[IDX_WIDTH+1:2] : '0;
            r_mem_wdata <= w_legal ? w_wdata : '0;
          end
        end
        ACCESS: begin
          r_state     <= RESP;
          r_mem_en    <= 1'b0;
          r_mem_we    <= 1'b0;
          r_mem_idx   <= '0;
          r_mem_wdata <= '0;
          r_rsp_valid <= r_owner ? 2'b10 : 2'b01;
          r_rsp_err   <= ~r_legal;
        end
        RESP: begin
          r_state     <= IDLE;
          r_rsp_valid <= 2'b00;
          r_rsp_err   <= 1'b0;
        end
        default: r_state <= IDLE;
      endcase
    end
  end

  // Memory read data arrives in RESP, so load data is forwarded straight through.
  assign bus.rsp_rdata = ((r_state == RESP) && r_legal && !r_we) ? bus.mem_rdata : '0;
  assign bus.req_ready = w_ready;
  assign bus.rsp_valid = r_rsp_valid;
  assign bus.rsp_err   = r_rsp_err;
  assign bus.mem_en    = r_mem_en;
  assign bus.mem_we    = r_mem_we;
  assign bus.mem_idx   = r_mem_idx;
  assign bus.mem_wdata = r_mem_wdata;

endmodule
